fetch_decode_buf: RTL and testbench

- Elastic IF/ID boundary between the fetch stage and the decode stage.
- Buffers up to DEPTH fetched {instr, pc2} pairs and decouples fetch from decode stalls with a valid/ready handshake.
- Drops all buffered work on a branch/jump flush.
- Detects HALT and back-pressures fetch once a HALT has been accepted.
- f_ready drives the fetch PC write-enable (PC advances only on accept).

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_decode_buf_if.sv | 26 ++
 rtl/fd_buf_ctrl.sv | 53 +++++
 rtl/fetch_decode_buf.sv | 48 ++++
 tb/tb_fetch_decode_buf.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the fetch/decode entry type
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  HALT_OP   = 5'b00000;
    localparam int          OP_MSB    = 15;
    localparam int          OP_LSB    = 11;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } fd_entry_t;

endpackage

// File: rtl/fetch_decode_buf_if.sv
// rtl/fetch_decode_buf_if.sv - fetch/decode handshake bundle for the IF/ID buffer
interface fetch_decode_buf_if #(
    parameter int DEPTH = 2
);
    logic                     f_valid;
    logic [15:0]              f_instr;
    logic [15:0]              f_pc2;
    logic                     f_ready;
    logic                     d_valid;
    logic [15:0]              d_instr;
    logic [15:0]              d_pc2;
    logic                     d_ready;
    logic                     flush;
    logic                     halted;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output f_valid, f_instr, f_pc2, d_ready, flush,
        input  f_ready, d_valid, d_instr, d_pc2, halted, count
    );

    modport slave (
        input  f_valid, f_instr, f_pc2, d_ready, flush,
        output f_ready, d_valid, d_instr, d_pc2, halted, count
    );
endinterface

// File: rtl/fd_buf_ctrl.sv
// rtl/fd_buf_ctrl.sv - pointer/occupancy/halt state and ready/valid generation
module fd_buf_ctrl #(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_valid,
    input  logic          f_is_halt,
    input  logic          d_ready,
    input  logic          flush,
    output logic          f_ready,
    output logic          d_valid,
    output logic          push,
    output logic [PW-1:0] wptr,
    output logic [PW-1:0] rptr,
    output logic [CW-1:0] count,
    output logic          halted
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic pop;

    // Ready/valid come only from registered state, so no path from d_ready/f_valid.
    assign f_ready = (count != FULL) & ~halted;
    assign d_valid = (count != '0);
    assign push    = f_valid & f_ready;
    assign pop     = d_valid & d_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else if (flush) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && f_is_halt) halted <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_decode_buf.sv
// rtl/fetch_decode_buf.sv - elastic IF/ID buffer: entry storage and head read mux
module fetch_decode_buf #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter logic [4:0]  HALT_OP   = cpu_pkg::HALT_OP
) (
    input  logic                clk,
    input  logic                rst,
    fetch_decode_buf_if.slave   bus
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);

    fd_entry_t       mem [DEPTH];
    fd_entry_t       head;
    logic            push;
    logic            f_is_halt;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;

    assign f_is_halt = (bus.f_instr[OP_MSB:OP_LSB] == HALT_OP);

    fd_buf_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .f_valid   (bus.f_valid),
        .f_is_halt (f_is_halt),
        .d_ready   (bus.d_ready),
        .flush     (bus.flush),
        .f_ready   (bus.f_ready),
        .d_valid   (bus.d_valid),
        .push      (push),
        .wptr      (wptr),
        .rptr      (rptr),
        .count     (bus.count),
        .halted    (bus.halted)
    );

    // Storage is not reset; the head mux below hides stale contents when empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{instr: bus.f_instr, pc2: bus.f_pc2};
    end

    assign head        = mem[rptr];
    assign bus.d_instr = bus.d_valid ? head.instr : NOP_INSTR;
    assign bus.d_pc2   = bus.d_valid ? head.pc2   : 16'h0000;
endmodule

// File: tb/tb_fetch_decode_buf.sv
// tb/tb_fetch_decode_buf.sv - self-checking bench for fetch_decode_buf
module tb_fetch_decode_buf;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fetch_decode_buf_if #(.DEPTH(DEPTH)) bus ();

    fetch_decode_buf #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        fv;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        dr;
        logic        fl;
        logic        e_dv;
        logic [15:0] e_di;
        logic [15:0] e_dp;
        int          e_cnt;
        logic        e_fr;
        logic        e_h;
    } vec_t;

    vec_t vec [12];

    logic [31:0] mq[$];
    logic        m_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [15:0] ins, input logic [15:0] pc,
                         input logic dr, input logic fl);
        bus.f_valid = fv;
        bus.f_instr = ins;
        bus.f_pc2   = pc;
        bus.d_ready = dr;
        bus.flush   = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mq.delete();
        m_halt = 1'b0;
    endtask

    // Reference model: a plain queue of entries plus a sticky halt flag.
    task automatic model_cycle();
        bit m_fr, m_push, m_pop;
        m_fr   = (mq.size() < DEPTH) && !m_halt;
        m_push = bus.f_valid && m_fr;
        m_pop  = (mq.size() > 0) && bus.d_ready;
        @(posedge clk);
        if (bus.flush) begin
            mq.delete();
            m_halt = 1'b0;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back({bus.f_instr, bus.f_pc2});
                if (bus.f_instr[15:11] == 5'b00000) m_halt = 1'b1;
            end
        end
        #1;
    endtask

    task automatic model_check(input string tag);
        logic [31:0] hd;
        hd = (mq.size() > 0) ? mq[0] : {16'h0800, 16'h0000};
        check({tag, " d_valid"}, 32'(bus.d_valid), 32'(mq.size() > 0));
        check({tag, " d_instr"}, 32'(bus.d_instr), 32'(hd[31:16]));
        check({tag, " d_pc2"},   32'(bus.d_pc2),   32'(hd[15:0]));
        check({tag, " count"},   32'(bus.count),   32'(mq.size()));
        check({tag, " f_ready"}, 32'(bus.f_ready), 32'((mq.size() < DEPTH) && !m_halt));
        check({tag, " halted"},  32'(bus.halted),  32'(m_halt));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        m_halt  = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

        //                fv  instr     pc2       dr  fl  dv  d_instr   d_pc2    cnt fr  h
        vec[0]  = '{1'b1, 16'h4001, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h4001, 16'h0002, 1, 1'b1, 1'b0};
        vec[1]  = '{1'b1, 16'h4002, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h4001, 16'h0002, 2, 1'b0, 1'b0};
        vec[2]  = '{1'b1, 16'h4003, 16'h0006, 1'b0, 1'b0, 1'b1, 16'h4001, 16'h0002, 2, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4002, 16'h0004, 1, 1'b1, 1'b0};
        vec[4]  = '{1'b1, 16'h4004, 16'h0008, 1'b0, 1'b0, 1'b1, 16'h4002, 16'h0004, 2, 1'b0, 1'b0};
        vec[5]  = '{1'b1, 16'h5555, 16'h000a, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h0000, 0, 1'b1, 1'b0};
        vec[6]  = '{1'b1, 16'h0000, 16'h000c, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h000c, 1, 1'b0, 1'b1};
        vec[7]  = '{1'b1, 16'h4003, 16'h000e, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h000c, 1, 1'b0, 1'b1};
        vec[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 0, 1'b0, 1'b1};
        vec[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0000, 0, 1'b1, 1'b0};
        vec[10] = '{1'b1, 16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0000, 0, 1'b1, 1'b0};
        vec[11] = '{1'b1, 16'h4010, 16'h0012, 1'b1, 1'b0, 1'b1, 16'h4010, 16'h0012, 1, 1'b1, 1'b0};

        do_reset();
        #1;
        check("reset d_valid", 32'(bus.d_valid), 32'd0);
        check("reset d_instr", 32'(bus.d_instr), 32'h0800);
        check("reset d_pc2",   32'(bus.d_pc2),   32'h0000);
        check("reset f_ready", 32'(bus.f_ready), 32'd1);
        check("reset count",   32'(bus.count),   32'd0);
        check("reset halted",  32'(bus.halted),  32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].fv, vec[i].instr, vec[i].pc2, vec[i].dr, vec[i].fl);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d d_valid", i), 32'(bus.d_valid), 32'(vec[i].e_dv));
            check($sformatf("vec%0d d_instr", i), 32'(bus.d_instr), 32'(vec[i].e_di));
            check($sformatf("vec%0d d_pc2", i),   32'(bus.d_pc2),   32'(vec[i].e_dp));
            check($sformatf("vec%0d count", i),   32'(bus.count),   32'(vec[i].e_cnt));
            check($sformatf("vec%0d f_ready", i), 32'(bus.f_ready), 32'(vec[i].e_fr));
            check($sformatf("vec%0d halted", i),  32'(bus.halted),  32'(vec[i].e_h));
        end

        // Streaming: one instruction per cycle, in order, across pointer wraps.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'h4000 + 16'(k), 16'(2 * k), 1'b1, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d count", k), 32'(bus.count), 32'd1);
            check($sformatf("stream%0d d_instr", k), 32'(bus.d_instr), 32'(16'h4000 + 16'(k)));
        end

        // Asynchronous reset with a full, halted buffer.
        do_reset();
        drive(1'b1, 16'h4001, 16'h0002, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 16'h0000, 16'h0004, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("pre-arst count",  32'(bus.count),  32'd2);
        check("pre-arst halted", 32'(bus.halted), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst d_valid", 32'(bus.d_valid), 32'd0);
        check("arst d_instr", 32'(bus.d_instr), 32'h0800);
        check("arst d_pc2",   32'(bus.d_pc2),   32'h0000);
        check("arst count",   32'(bus.count),   32'd0);
        check("arst halted",  32'(bus.halted),  32'd0);
        do_reset();
        #1;
        check("post-arst f_ready", 32'(bus.f_ready), 32'd1);

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 19) == 0) ins[15:11] = 5'b00000;
            else if (ins[15:11] == 5'b00000) ins[15:11] = 5'b01000;
            drive(1'($urandom_range(0, 3) != 0), ins, 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
            model_cycle();
            model_check($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
